ram_rr_arbiter: RTL and testbench
=================================

Name: ram_rr_arbiter

Overview:
- Round-robin arbiter sharing the single RAM port between NREQ cache requesters (icache0, dcache0, icache1, dcache1 by index).
- Sits between the cache-side request ports and the RAM.
- Sequences one- or two-word bursts per grant and generates beat addresses itself.
- The coherence bus controller feeds its RAM-side requests in as requester ports.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 32, address width
DW, 32, data width

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
req  in  NREQ  request per requester; held until last beat is acknowledged
wen  in  NREQ  1=write, 0=read; sampled at grant
burst2  in  NREQ  1=two-word burst, 0=single word; sampled at grant
addr  in  NREQ*AW  word-aligned base address, slice i = requester i
store  in  NREQ*DW  write data, slice i; requester updates it after each beat ack
ramstate  in  2  RAM status (FREE, BUSY, ACCESS, ERROR)
ramload  in  DW  RAM read data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  AW  RAM address
ramstore  out  DW  RAM write data
grant  out  NREQ  one-hot registered grant
ack  out  NREQ  per-requester beat acknowledge (combinational on ACCESS)
rload  out  DW  ramload forwarded to all requesters, valid when ack set
busy  out  1  arbiter holding a grant

Behaviour:
- Reset (RST high at CLK edge):
  - state=IDLE, grant=0, beat=0, ptr=0.
  - All RAM enables 0, ramaddr=0, ramstore=0, ack=0, busy=0.
  - Reset mid-burst aborts immediately; RAM enables drop in the cycle after the edge.
- State IDLE:
  - Outputs are idle.
  - If any req is high, select the first requester with req high, searching from ptr upward and wrapping modulo NREQ.
  - Next edge: grant<=onehot(sel), latch wen/burst2 of sel into op_wen/op_b2, beat<=0, go XFER.
  - Arbitration costs exactly one cycle. req rising in cycle 0 gives ramREN/ramWEN high in cycle 1.
- State XFER (g = granted index, busy=1):
  - ramaddr = addr[g] + (beat<<2).
  - ramREN = ~op_wen & req[g]; ramWEN = op_wen & req[g].
  - ramstore = store[g].
  - ack[g] = (ramstate==ACCESS) & req[g]; rload = ramload.
- XFER transitions:
  - ACCESS with beat==op_b2 (last beat): go IDLE, grant<=0, ptr<=(g+1) mod NREQ.
  - ACCESS with beat<op_b2: beat<=1, stay in XFER. The next beat is issued the following cycle with no IDLE gap.
  - BUSY or FREE: hold; all outputs stable.
  - ERROR: hold and retry the same beat; no ack.
  - req[g] low (abort): enables drop combinationally; next edge go IDLE. ptr still advances to (g+1) mod NREQ, so a withdrawn requester cannot starve others.
- Fairness:
  - A requester that has just completed becomes lowest priority.
  - With all NREQ requesting continuously, grants rotate 0,1,2,3,0...
  - Worst-case wait is NREQ-1 bursts plus arbitration cycles.
- Simultaneous events:
  - New req edges during XFER are not considered until IDLE.
  - If the last-beat ACCESS coincides with req[g] dropping, the burst counts as complete.
- Invariants:
  - grant is zero or one-hot.
  - ramREN & ramWEN is never 1.
  - ack is zero unless state is XFER.
- Width rules:
  - Beat address offset is +4 bytes; adder wraps modulo 2^AW (base 0xFFFFFFFC burst2 gives beat1 addr 0x00000000).
  - ptr width is clog2(NREQ).

Test Plan:
- Single read: req[1]=1, wen=0, burst2=0, addr=0x100, RAM gives ACCESS 2 cycles after ramREN -> grant=0010 at cycle 1; ramaddr=0x100; ack[1] one cycle with rload=RAM data; IDLE; ptr=2.
- Two-word write: req[3], wen=1, burst2=1, addr=0x200, store 0xAAAA then 0xBBBB -> ramWEN beats at 0x200/0x204 with matching ramstore; two ack[3] pulses; ptr=0.
- Contention: req=1111 held, all single reads, ptr=0 -> grant order 0,1,2,3,0; no requester granted twice before all are served.
- Abort: req[2] drops during beat0 of a burst2 read -> ramREN low that cycle; next cycle IDLE; no ack[2]; ptr=3; pending req[0] granted next.
- ERROR retry: ramstate ERROR 3 cycles then ACCESS on a read of 0x40 -> ramaddr stays 0x40, no ack until ACCESS, then single ack.
- Reset mid-burst: RST high during beat1 of burst2 -> next cycle grant=0, enables 0, busy=0, ptr=0; a fresh req[0] is granted 1 cycle after RST low.

Source files
------------

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter that shares one RAM port between NREQ cache-side requesters.
// Each grant runs a one- or two-word burst. Beat addresses are generated here as
// base + 4*beat, wrapping modulo 2^AW. A requester that has just finished, or has
// withdrawn, drops to lowest priority.
module ram_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      wen,
    input  logic [NREQ-1:0]      burst2,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   store,
    input  logic [1:0]           ramstate,
    input  logic [DW-1:0]        ramload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [AW-1:0]        ramaddr,
    output logic [DW-1:0]        ramstore,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      ack,
    output logic [DW-1:0]        rload,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic {IDLE, XFER} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]     gidx_q, gidx_d;
    logic              beat_q, beat_d;
    logic              op_wen_q, op_wen_d;
    logic              op_b2_q, op_b2_d;
    logic [PW-1:0]     ptr_q, ptr_d;

    logic [AW-1:0]     addr_arr [NREQ];
    logic [DW-1:0]     store_arr [NREQ];

    logic              sel_valid;
    logic [PW-1:0]     sel_idx;
    int                sel_scan;
    logic [PW-1:0]     ptr_inc;
    logic              req_g;

    // Split the flat per-requester buses into indexable arrays.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr[gi*AW +: AW];
            assign store_arr[gi] = store[gi*DW +: DW];
        end
    endgenerate

    // The granted requester's request line gates every RAM-side action.
    assign req_g   = req[gidx_q];
    // Priority pointer after the current grant ends: the slot just past it.
    assign ptr_inc = (gidx_q == PW'(NREQ-1)) ? '0 : gidx_q + 1'b1;

    // Round-robin search: scan from ptr upward, wrapping; scanning the offsets
    // from high to low lets the closest active requester win the last assignment.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_scan  = 0;
        for (int k = NREQ-1; k >= 0; k--) begin
            sel_scan = int'(ptr_q) + k;
            if (sel_scan >= NREQ) begin
                sel_scan = sel_scan - NREQ;
            end
            if (req[sel_scan]) begin
                sel_valid = 1'b1;
                sel_idx   = sel_scan[PW-1:0];
            end
        end
    end

    // Next-state logic: arbitration in IDLE, beat sequencing and abort handling in XFER.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        beat_d   = beat_q;
        op_wen_d = op_wen_q;
        op_b2_d  = op_b2_q;
        ptr_d    = ptr_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d  = XFER;
                    grant_d  = NREQ'(1) << sel_idx;
                    gidx_d   = sel_idx;
                    op_wen_d = wen[sel_idx];
                    op_b2_d  = burst2[sel_idx];
                    beat_d   = 1'b0;
                end
            end
            XFER: begin
                if (!req_g) begin
                    // Withdrawn request: release, still rotating priority past it.
                    state_d = IDLE;
                    grant_d = '0;
                    beat_d  = 1'b0;
                    ptr_d   = ptr_inc;
                end else begin
                    case (ramstate)
                        RS_ACCESS: begin
                            if (beat_q == op_b2_q) begin
                                state_d = IDLE;
                                grant_d = '0;
                                beat_d  = 1'b0;
                                ptr_d   = ptr_inc;
                            end else begin
                                beat_d = 1'b1;
                            end
                        end
                        RS_ERROR, RS_BUSY, RS_FREE: begin
                            // Hold the current beat; ERROR simply retries it.
                            beat_d = beat_q;
                        end
                        default: begin
                            beat_d = beat_q;
                        end
                    endcase
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            beat_q   <= 1'b0;
            op_wen_q <= 1'b0;
            op_b2_q  <= 1'b0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            beat_q   <= beat_d;
            op_wen_q <= op_wen_d;
            op_b2_q  <= op_b2_d;
            ptr_q    <= ptr_d;
        end
    end

    // RAM-side and requester-side outputs; everything idles outside XFER.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ack      = '0;
        rload    = '0;
        busy     = 1'b0;
        if (state_q == XFER) begin
            busy         = 1'b1;
            ramaddr      = addr_arr[gidx_q] + {{(AW-3){1'b0}}, beat_q, 2'b00};
            ramREN       = ~op_wen_q & req_g;
            ramWEN       = op_wen_q & req_g;
            ramstore     = store_arr[gidx_q];
            rload        = ramload;
            ack[gidx_q]  = (ramstate == RS_ACCESS) & req_g;
        end
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Testbench for ram_rr_arbiter: directed scenarios plus randomized multi-requester
// rounds checked against a transaction-level round-robin model.
module tb_ram_rr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_ERROR  = 2'd3;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ-1:0]     wen = '0;
    logic [NREQ-1:0]     burst2 = '0;
    logic [NREQ*AW-1:0]  addr = '0;
    logic [NREQ*DW-1:0]  store = '0;
    logic [1:0]          ramstate = S_FREE;
    logic [DW-1:0]       ramload = '0;
    logic                ramREN, ramWEN;
    logic [AW-1:0]       ramaddr;
    logic [DW-1:0]       ramstore;
    logic [NREQ-1:0]     grant, ack;
    logic [DW-1:0]       rload;
    logic                busy;

    int errors = 0;
    int checks = 0;
    int model_ptr = 0;

    ram_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST), .req(req), .wen(wen), .burst2(burst2),
        .addr(addr), .store(store), .ramstate(ramstate), .ramload(ramload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .grant(grant), .ack(ack), .rload(rload), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge; inputs are then driven and
    // outputs sampled 1 time unit later, well away from the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic b2,
                           input logic [AW-1:0] a, input logic [DW-1:0] s);
        req[i]              = 1'b1;
        wen[i]              = w;
        burst2[i]           = b2;
        addr[i*AW +: AW]    = a;
        store[i*DW +: DW]   = s;
    endtask

    task automatic test_reset();
        RST = 1'b1; req = '0; ramstate = S_FREE;
        tick(); tick(); #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL reset_en: got REN=%b WEN=%b expected 0/0", ramREN, ramWEN); end
        checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++; $display("FAIL reset_bus: got addr=%h store=%h expected 0/0", ramaddr, ramstore); end
        checks++; if (ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL reset_ack_busy: got ack=%b busy=%b expected 0000/0", ack, busy); end
        tick(); RST = 1'b0;
        model_ptr = 0;
        $display("reset: done");
    endtask

    task automatic test_single_read();
        logic [DW-1:0] d;
        d = $urandom;
        tick(); set_req(1, 1'b0, 1'b0, 32'h100, 32'h0); ramstate = S_FREE; #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_arb_cycle: got grant=%b busy=%b expected 0000/0", grant, busy); end
        tick(); #1;
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b expected 0010", grant); end
        checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0) begin errors++; $display("FAIL single_en: got REN=%b WEN=%b expected 1/0", ramREN, ramWEN); end
        checks++; if (ramaddr !== 32'h100) begin errors++; $display("FAIL single_addr: got %h expected 00000100", ramaddr); end
        tick(); ramstate = S_BUSY; #1;
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_noack_busy: got %b expected 0000", ack); end
        tick(); ramstate = S_ACCESS; ramload = d; #1;
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL single_ack: got %b expected 0010", ack); end
        checks++; if (rload !== d) begin errors++; $display("FAIL single_rload: got %h expected %h", rload, d); end
        tick(); req[1] = 1'b0; ramstate = S_FREE; #1;
        checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL single_idle: got busy=%b grant=%b expected 0/0000", busy, grant); end
        model_ptr = 2;
        $display("single_read: addr=100 data=%h", d);
    endtask

    task automatic test_two_word();
        tick(); set_req(3, 1'b1, 1'b1, 32'h200, 32'hAAAA); ramstate = S_FREE; #1;
        tick(); #1;
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL wr2_grant: got %b expected 1000", grant); end
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL wr2_en: got REN=%b WEN=%b expected 0/1", ramREN, ramWEN); end
        checks++; if (ramaddr !== 32'h200 || ramstore !== 32'hAAAA) begin errors++; $display("FAIL wr2_beat0: got addr=%h store=%h expected 200/AAAA", ramaddr, ramstore); end
        tick(); ramstate = S_ACCESS; #1;
        checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL wr2_ack0: got %b expected 1000", ack); end
        tick(); store[3*DW +: DW] = 32'hBBBB; ramstate = S_BUSY; #1;
        checks++; if (ramWEN !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL wr2_nogap: got WEN=%b busy=%b expected 1/1", ramWEN, busy); end
        checks++; if (ramaddr !== 32'h204 || ramstore !== 32'hBBBB) begin errors++; $display("FAIL wr2_beat1: got addr=%h store=%h expected 204/BBBB", ramaddr, ramstore); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL wr2_noack_busy: got %b expected 0000", ack); end
        tick(); ramstate = S_ACCESS; #1;
        checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL wr2_ack1: got %b expected 1000", ack); end
        tick(); req[3] = 1'b0; ramstate = S_FREE; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr2_idle: got busy=%b expected 0", busy); end
        model_ptr = 0;
        $display("two_word: 200/204 written");
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] seen;
        logic [NREQ-1:0] eg;
        int exp_g;
        seen = '0;
        tick();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 32'(i * 16), 32'h0);
        ramstate = S_FREE; #1;
        for (int k = 0; k < 5; k++) begin
            exp_g = model_ptr;
            eg = 4'b0001 << exp_g;
            tick(); ramstate = S_ACCESS; #1;
            checks++; if (grant !== eg) begin errors++; $display("FAIL contention_grant[%0d]: got %b expected %b", k, grant, eg); end
            checks++; if (ack !== eg || ramaddr !== 32'(exp_g * 16)) begin errors++; $display("FAIL contention_xfer[%0d]: got ack=%b addr=%h expected %b/%h", k, ack, ramaddr, eg, 32'(exp_g * 16)); end
            if (k < NREQ) begin
                checks++; if ((seen & grant) !== 4'b0000) begin errors++; $display("FAIL contention_twice[%0d]: got grant=%b already seen=%b", k, grant, seen); end
                seen = seen | grant;
            end
            tick(); ramstate = S_FREE;
            if (k == 4) req = '0;
            #1;
            model_ptr = (exp_g + 1) % NREQ;
            $display("contention: grant %0d -> %b", k, grant);
        end
    endtask

    task automatic test_abort();
        int a, b;
        a = model_ptr;
        b = (a + NREQ - 1) % NREQ;
        tick(); set_req(a, 1'b0, 1'b1, 32'h300, 32'h0); set_req(b, 1'b0, 1'b0, 32'h400, 32'h0); ramstate = S_BUSY; #1;
        tick(); #1;
        checks++; if (grant !== (4'b0001 << a) || ramREN !== 1'b1) begin errors++; $display("FAIL abort_grant: got grant=%b REN=%b expected %b/1", grant, ramREN, 4'b0001 << a); end
        tick(); req[a] = 1'b0; ramstate = S_ACCESS; #1;
        checks++; if (ramREN !== 1'b0 || ack !== 4'b0000) begin errors++; $display("FAIL abort_drop: got REN=%b ack=%b expected 0/0000", ramREN, ack); end
        tick(); set_req(a, 1'b0, 1'b0, 32'h500, 32'h0); ramstate = S_FREE; #1;
        checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL abort_idle: got busy=%b grant=%b expected 0/0000", busy, grant); end
        tick(); ramstate = S_ACCESS; #1;
        checks++; if (grant !== (4'b0001 << b) || ramaddr !== 32'h400) begin errors++; $display("FAIL abort_next: got grant=%b addr=%h expected %b/400", grant, ramaddr, 4'b0001 << b); end
        tick(); req[b] = 1'b0; ramstate = S_FREE; #1;
        tick(); ramstate = S_ACCESS; #1;
        checks++; if (grant !== (4'b0001 << a) || ack !== (4'b0001 << a)) begin errors++; $display("FAIL abort_regrant: got grant=%b ack=%b expected %b", grant, ack, 4'b0001 << a); end
        tick(); req[a] = 1'b0; ramstate = S_FREE; #1;
        model_ptr = (a + 1) % NREQ;
        $display("abort: requester %0d withdrawn, %0d served", a, b);
    endtask

    task automatic test_error_retry();
        int g;
        logic [DW-1:0] d;
        g = model_ptr;
        d = $urandom;
        tick(); set_req(g, 1'b0, 1'b0, 32'h40, 32'h0); ramstate = S_FREE; #1;
        for (int i = 0; i < 3; i++) begin
            tick(); ramstate = S_ERROR; #1;
            checks++; if (ramaddr !== 32'h40 || ramREN !== 1'b1 || ack !== 4'b0000) begin errors++; $display("FAIL error_hold[%0d]: got addr=%h REN=%b ack=%b expected 40/1/0000", i, ramaddr, ramREN, ack); end
        end
        tick(); ramstate = S_ACCESS; ramload = d; #1;
        checks++; if (ack !== (4'b0001 << g) || rload !== d) begin errors++; $display("FAIL error_ack: got ack=%b rload=%h expected %b/%h", ack, rload, 4'b0001 << g, d); end
        tick(); req[g] = 1'b0; ramstate = S_FREE; #1;
        checks++; if (ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL error_single: got ack=%b busy=%b expected 0000/0", ack, busy); end
        model_ptr = (g + 1) % NREQ;
        $display("error_retry: requester %0d", g);
    endtask

    task automatic test_addr_wrap();
        int g;
        g = model_ptr;
        tick(); set_req(g, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0); ramstate = S_FREE; #1;
        tick(); ramstate = S_ACCESS; #1;
        checks++; if (ramaddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_beat0: got %h expected FFFFFFFC", ramaddr); end
        tick(); ramstate = S_ACCESS; #1;
        checks++; if (ramaddr !== 32'h0000_0000 || ack !== (4'b0001 << g)) begin errors++; $display("FAIL wrap_beat1: got addr=%h ack=%b expected 00000000/%b", ramaddr, ack, 4'b0001 << g); end
        tick(); req[g] = 1'b0; ramstate = S_FREE; #1;
        model_ptr = (g + 1) % NREQ;
        $display("addr_wrap: requester %0d", g);
    endtask

    task automatic test_reset_mid_burst();
        tick(); RST = 1'b1; req = '0; ramstate = S_FREE; #1;
        tick(); RST = 1'b0; set_req(0, 1'b0, 1'b0, 32'h10, 32'h0); #1;
        tick(); ramstate = S_ACCESS; #1;
        tick(); req[0] = 1'b0; ramstate = S_FREE; #1;
        tick(); set_req(1, 1'b0, 1'b1, 32'h80, 32'h0); #1;
        tick(); ramstate = S_ACCESS; #1;
        checks++; if (grant !== 4'b0010 || ack !== 4'b0010) begin errors++; $display("FAIL rstmid_beat0: got grant=%b ack=%b expected 0010/0010", grant, ack); end
        tick(); ramstate = S_BUSY; RST = 1'b1; #1;
        checks++; if (ramaddr !== 32'h84 || ramREN !== 1'b1) begin errors++; $display("FAIL rstmid_beat1: got addr=%h REN=%b expected 84/1", ramaddr, ramREN); end
        tick(); RST = 1'b0; req = '0; set_req(0, 1'b0, 1'b0, 32'h20, 32'h0); set_req(3, 1'b0, 1'b0, 32'h30, 32'h0); ramstate = S_FREE; #1;
        checks++; if (grant !== 4'b0000 || ramREN !== 1'b0 || ramWEN !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_abort: got grant=%b REN=%b WEN=%b busy=%b expected 0000/0/0/0", grant, ramREN, ramWEN, busy); end
        tick(); ramstate = S_ACCESS; #1;
        checks++; if (grant !== 4'b0001 || ramaddr !== 32'h20) begin errors++; $display("FAIL rstmid_ptr: got grant=%b addr=%h expected 0001/20", grant, ramaddr); end
        tick(); req[0] = 1'b0; ramstate = S_FREE; #1;
        tick(); ramstate = S_ACCESS; #1;
        tick(); req[3] = 1'b0; ramstate = S_FREE; #1;
        model_ptr = 0;
        $display("reset_mid_burst: done");
    endtask

    task automatic test_random();
        logic [NREQ-1:0] pending;
        logic            r_wen [NREQ];
        logic            r_b2  [NREQ];
        logic [AW-1:0]   r_addr[NREQ];
        logic [DW-1:0]   r_data[NREQ][2];
        logic [NREQ-1:0] eg;
        logic [AW-1:0]   ea;
        logic [DW-1:0]   ld;
        int g, w, t;
        for (int round = 0; round < 30; round++) begin
            pending = 4'($urandom_range(1, 15));
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (pending[i]) begin
                    r_wen[i]     = 1'($urandom);
                    r_b2[i]      = 1'($urandom);
                    r_addr[i]    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                    r_data[i][0] = $urandom;
                    r_data[i][1] = $urandom;
                    set_req(i, r_wen[i], r_b2[i], r_addr[i], r_data[i][0]);
                end
            end
            ramstate = S_FREE; #1;
            for (int n = 0; n < NREQ && pending != '0; n++) begin
                g = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && pending[(model_ptr + k) % NREQ]) g = (model_ptr + k) % NREQ;
                end
                eg = 4'b0001 << g;
                for (int b = 0; b <= int'(r_b2[g]); b++) begin
                    w = $urandom_range(0, 2);
                    ea = r_addr[g] + 32'(b * 4);
                    for (int c = 0; c <= w; c++) begin
                        tick();
                        store[g*DW +: DW] = r_data[g][b];
                        t = $urandom_range(0, 2);
                        ramstate = (c == w) ? S_ACCESS : ((t == 2) ? S_ERROR : 2'(t));
                        ld = $urandom;
                        ramload = ld;
                        #1;
                        checks++; if (grant !== eg || busy !== 1'b1) begin errors++; $display("FAIL rand_grant r%0d: got grant=%b busy=%b expected %b/1", round, grant, busy, eg); end
                        checks++; if (ramaddr !== ea || ramstore !== r_data[g][b]) begin errors++; $display("FAIL rand_bus r%0d: got addr=%h store=%h expected %h/%h", round, ramaddr, ramstore, ea, r_data[g][b]); end
                        checks++; if (ramREN !== ~r_wen[g] || ramWEN !== r_wen[g]) begin errors++; $display("FAIL rand_en r%0d: got REN=%b WEN=%b expected %b/%b", round, ramREN, ramWEN, ~r_wen[g], r_wen[g]); end
                        checks++; if (ack !== ((c == w) ? eg : 4'b0000)) begin errors++; $display("FAIL rand_ack r%0d: got %b expected %b", round, ack, (c == w) ? eg : 4'b0000); end
                        if (c == w && !r_wen[g]) begin
                            checks++; if (rload !== ld) begin errors++; $display("FAIL rand_rload r%0d: got %h expected %h", round, rload, ld); end
                        end
                    end
                end
                tick(); req[g] = 1'b0; pending[g] = 1'b0; ramstate = S_FREE; #1;
                checks++; if (busy !== 1'b0 || grant !== 4'b0000 || ack !== 4'b0000) begin errors++; $display("FAIL rand_idle r%0d: got busy=%b grant=%b ack=%b expected 0/0000/0000", round, busy, grant, ack); end
                model_ptr = (g + 1) % NREQ;
                $display("random r%0d: granted %0d wen=%b b2=%b addr=%h", round, g, r_wen[g], r_b2[g], r_addr[g]);
            end
            checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rand_unserved r%0d: got pending=%b expected 0000", round, pending); end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_two_word();
        test_contention();
        test_abort();
        test_error_retry();
        test_addr_wrap();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
